period_meter: RTL
=================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 100, the clk frequency in MHz.
REQ-002 SHALL have parameter FREQ_KHZ_MIN, default 100, the lowest accepted drive frequency (sets CNT_MAX).
REQ-003 SHALL have parameter FREQ_KHZ_MAX, default 400, the highest accepted drive frequency (sets CNT_MIN).
REQ-004 SHALL have parameter GEN_PARAMETER, default 255, the maximum code value; code width W = bits to hold GEN_PARAMETER (8 at default).
REQ-005 SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port inp, input, 1 bit: the square-wave drive signal, asynchronous to clk.
REQ-008 SHALL have port code, output, W bits: the measured generator parameter.
REQ-009 SHALL have port valid, output, 1 bit: one-cycle strobe marking a new result.
REQ-010 SHALL have port locked, output, 1 bit: level, high while in-range results are arriving.
REQ-011 SHALL have port too_fast, output, 1 bit: registered with each result; interval below range.
REQ-012 SHALL have port too_slow, output, 1 bit: registered with each result; interval above range.

Function
REQ-013 SHALL compute CNT_MIN = 500*CLK_MHZ/FREQ_KHZ_MAX and CNT_MAX = 500*CLK_MHZ/FREQ_KHZ_MIN using integer division (defaults 125 and 500).
REQ-014 SHALL resynchronise inp through two clk flops, then detect both edges; an edge pulse lasts one cycle, 3 cycles after the inp transition.
REQ-015 SHALL measure interval H as the clk cycles between consecutive edge pulses (pulses at t0 and t1 give H = t1-t0); the interval counter is wide enough for CNT_MAX+1 and never wraps.
REQ-016 SHALL have FSM states SEEK and MEAS: SEEK goes to MEAS on an edge pulse and emits no result; MEAS emits a result on each edge pulse and restarts the interval.
REQ-017 SHALL, in MEAS, time out when H reaches CNT_MAX+1 with no edge: go to SEEK, clear locked, emit no valid.
REQ-018 SHALL give an edge pulse priority over timeout in the same cycle; that interval is a result with too_slow=1.
REQ-019 SHALL set code = H-CNT_MIN when CNT_MIN <= H <= CNT_MIN+GEN_PARAMETER, with too_fast=0 and too_slow=0.
REQ-020 SHALL, when H < CNT_MIN, set code=0 and too_fast=1.
REQ-021 SHALL, when H > CNT_MIN+GEN_PARAMETER, set code=GEN_PARAMETER and too_slow=1.
REQ-022 SHALL register code, too_fast and too_slow and pulse valid for 1 cycle, all in the cycle after the edge pulse; these outputs hold their values between results.
REQ-023 SHALL set locked=1 with each in-range result and clear it with each out-of-range result or timeout.

Reset
REQ-024 SHALL, while rst=1, asynchronously force code=0, valid=0, locked=0, too_fast=0, too_slow=0, synchroniser flops=0, counter=0 and state=SEEK.
REQ-025 SHALL restart measurement from SEEK after rst is released mid-interval, discarding the partial interval; a synchroniser value of 1 after reset counts as an edge.

Configuration
REQ-026 SHALL, with macro PERIOD_AVG_EN defined, average pairs of intervals: results come on every second edge from H = (Ha+Hb)>>1 (truncated), which hides duty-cycle asymmetry.
REQ-027 SHALL, with PERIOD_AVG_EN defined, apply timeout to each half, discard any unpaired half on timeout, and restart pairing from SEEK.
REQ-028 SHALL, without PERIOD_AVG_EN, emit one result per edge as in REQ-016..023.

Verification
REQ-029 SHALL cover: a square wave with half period 225 clk (defaults) -> valid per edge, code=100, locked=1, flags 0.
REQ-030 SHALL cover: half period 100 -> code=0, too_fast=1, locked=0; half period 400 -> code=255, too_slow=1.
REQ-031 SHALL cover: inp held static for 600 cycles after lock -> locked drops exactly 501 cycles after the last edge pulse, with no valid.
REQ-032 SHALL cover: edge at H=501 coinciding with timeout -> result with code=255, too_slow=1, FSM stays MEAS.
REQ-033 SHALL cover: rst pulsed mid-interval -> all outputs 0 immediately; the first result after release comes one full interval later.
REQ-034 SHALL cover: alternating halves of 200/250 -> with PERIOD_AVG_EN, code=100 every second edge; without it, codes alternate 75/125.

Source files
------------

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// period_meter : square-wave half-period meter mapping each interval to a
//                generator code (optional pair averaging via PERIOD_AVG_EN)
// Revision 1.0 : initial release
// ============================================================================
module period_meter #(
    parameter int CLK_MHZ       = 100,
    parameter int FREQ_KHZ_MIN  = 100,
    parameter int FREQ_KHZ_MAX  = 400,
    parameter int GEN_PARAMETER = 255,
    localparam int W            = $clog2(GEN_PARAMETER + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inp,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         locked,
    output logic         too_fast,
    output logic         too_slow
);
    localparam int CNT_MIN  = (500 * CLK_MHZ) / FREQ_KHZ_MAX;
    localparam int CNT_MAX  = (500 * CLK_MHZ) / FREQ_KHZ_MIN;
    localparam int CNT_TO   = CNT_MAX + 1;
    localparam int CW       = $clog2(CNT_MAX + 2);
    localparam int CODE_TOP = CNT_MIN + GEN_PARAMETER;

    typedef enum logic [0:0] {
        SEEK = 1'b0,
        MEAS = 1'b1
    } state_t;

    logic          sync1_q, sync2_q, prev_q, edge_q;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic          emit_w, tmo_w;
    logic [CW-1:0] h_w;
    logic [31:0]   h_ext;
    logic [W-1:0]  code_d;
    logic          fast_d, slow_d;
    logic [W-1:0]  code_q;
    logic          valid_q, locked_q, fast_q, slow_q;

    // prev_q starts at 0, so a synchronised 1 after reset reads as an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= inp;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q ^ prev_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (edge_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CW'(CNT_TO)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

`ifdef PERIOD_AVG_EN
    logic [CW-1:0] half_q, half_d;
    logic          have_q, have_d;
    logic [CW:0]   pair_sum;

    assign pair_sum = {1'b0, half_q} + {1'b0, cnt_q};
    assign h_w      = CW'(pair_sum >> 1);
`else
    assign h_w = cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEEK;
            cnt_q   <= '0;
`ifdef PERIOD_AVG_EN
            half_q  <= '0;
            have_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef PERIOD_AVG_EN
            half_q  <= half_d;
            have_q  <= have_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        emit_w  = 1'b0;
        tmo_w   = 1'b0;
`ifdef PERIOD_AVG_EN
        half_d  = half_q;
        have_d  = have_q;
`endif
        case (state_q)
            SEEK: begin
                if (edge_q) begin
                    state_d = MEAS;
`ifdef PERIOD_AVG_EN
                    have_d  = 1'b0;
`endif
                end
            end
            MEAS: begin
                // an edge landing on the timeout cycle still yields a result
                if (edge_q) begin
`ifdef PERIOD_AVG_EN
                    if (have_q) begin
                        emit_w = 1'b1;
                        have_d = 1'b0;
                    end else begin
                        half_d = cnt_q;
                        have_d = 1'b1;
                    end
`else
                    emit_w = 1'b1;
`endif
                end else if (cnt_q == CW'(CNT_TO)) begin
                    state_d = SEEK;
                    tmo_w   = 1'b1;
`ifdef PERIOD_AVG_EN
                    have_d  = 1'b0;
`endif
                end
            end
            default: state_d = SEEK;
        endcase
    end

    assign h_ext = 32'(h_w);

    always_comb begin
        code_d = '0;
        fast_d = 1'b0;
        slow_d = 1'b0;
        if (h_ext < 32'(CNT_MIN)) begin
            fast_d = 1'b1;
        end else if (h_ext > 32'(CODE_TOP)) begin
            code_d = W'(GEN_PARAMETER);
            slow_d = 1'b1;
        end else begin
            code_d = W'(h_ext - 32'(CNT_MIN));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            fast_q   <= 1'b0;
            slow_q   <= 1'b0;
        end else begin
            valid_q <= emit_w;
            if (emit_w) begin
                code_q   <= code_d;
                fast_q   <= fast_d;
                slow_q   <= slow_d;
                locked_q <= ~(fast_d | slow_d);
            end else if (tmo_w) begin
                locked_q <= 1'b0;
            end
        end
    end

    assign code     = code_q;
    assign valid    = valid_q;
    assign locked   = locked_q;
    assign too_fast = fast_q;
    assign too_slow = slow_q;

endmodule
`default_nettype wire
